// File: rtl/mem_stage_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_stage_ctrl_if
// Data-memory request/valid bus between the MEM stage and a multi-cycle
// data memory.
//   dmem_req    master->slave  access request (held for the whole access)
//   dmem_we     master->slave  1 = write, 0 = read
//   dmem_addr   master->slave  16-bit word address
//   dmem_wdata  master->slave  16-bit store data
//   dmem_rdata  slave->master  16-bit load data, valid with dmem_valid
//   dmem_valid  slave->master  access complete
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface mem_stage_ctrl_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_valid;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_valid
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_valid
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_ctrl
// MEM stage of the 16-bit five-stage pipeline. Consumes the EX/MEM register,
// runs loads/stores against a multi-cycle data memory, stalls the front of
// the pipeline while an access is outstanding and owns the MEM/WB register.
//
// Parameters
//   MAX_WAIT  ACCESS cycles without dmem_valid before the access is forced
//             to complete with an error (1..255)
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   mem_read_in/_write_in    MemRead / MemWrite from EX/MEM
//   addr_in, wdata_in        ALU result (address) and rt value (store data)
//   src_reg2_in, dst_reg_in  store-data source reg, destination reg
//   wb_in                    WB control [3] RegWrite [2] MemtoReg
//                            [1] PCtoReg [0] Halt
//   dmem                     data-memory bus (master side)
//   mem_stall                hold PC, IF/ID, ID/EX, EX/MEM this cycle
//   mem_err                  sticky access-timeout flag
//   wb_out, dst_reg_out,
//   alu_data_out,
//   mem_data_out             MEM/WB register outputs
//
// Build option
//   MEM2MEM_FWD_EN  when defined, a store directly following a load/ALU
//                   instruction that writes its data register takes the
//                   data from MEM/WB instead of wdata_in.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_stage_ctrl #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read_in,
    input  logic               mem_write_in,
    input  logic [15:0]        addr_in,
    input  logic [15:0]        wdata_in,
    input  logic [3:0]         src_reg2_in,
    input  logic [3:0]         dst_reg_in,
    input  logic [3:0]         wb_in,
    mem_stage_ctrl_if.master   dmem,
    output logic               mem_stall,
    output logic               mem_err,
    output logic [3:0]         wb_out,
    output logic [3:0]         dst_reg_out,
    output logic [15:0]        alu_data_out,
    output logic [15:0]        mem_data_out
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;
    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    logic [0:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_dmem_req;
    logic        r_dmem_we;
    logic [15:0] r_dmem_addr;
    logic [15:0] r_dmem_wdata;
    logic        r_mem_err;
    logic [3:0]  r_wb_out;
    logic [3:0]  r_dst_reg_out;
    logic [15:0] r_alu_data_out;
    logic [15:0] r_mem_data_out;

    logic        w_access;
    logic        w_timeout;
    logic        w_stall;
    logic [15:0] w_store_data;

    assign w_access  = mem_read_in | mem_write_in;
    assign w_timeout = (r_cnt == LP_MAX_WAIT);

    // In ACCESS the stall drops in the very cycle the access completes, so
    // the instruction behind it advances on the same edge as MEM/WB capture.
    // Gating with rst keeps the pipeline free while reset is asserted.
    always_comb begin
        w_stall = 1'b0;
        if (r_state == S_IDLE) begin
            w_stall = w_access;
        end else begin
            w_stall = ~dmem.dmem_valid & ~w_timeout;
        end
        mem_stall = w_stall & ~rst;
    end

`ifdef MEM2MEM_FWD_EN
    // Store data comes from MEM/WB when the instruction just ahead writes
    // the store's source register (r0 is never a forwarding source).
    logic w_fwd_hit;
    assign w_fwd_hit = r_wb_out[3] & (r_dst_reg_out == src_reg2_in) &
                       (r_dst_reg_out != 4'd0) & mem_write_in;
    assign w_store_data = w_fwd_hit ? (r_wb_out[2] ? r_mem_data_out : r_alu_data_out)
                                    : wdata_in;
`else
    logic w_unused_src;
    assign w_unused_src = ^src_reg2_in;
    assign w_store_data = wdata_in;
`endif

    // Access FSM; bus fields are latched on entry and held for the access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= 8'd0;
            r_dmem_req     <= 1'b0;
            r_dmem_we      <= 1'b0;
            r_dmem_addr    <= 16'h0000;
            r_dmem_wdata   <= 16'h0000;
            r_mem_err      <= 1'b0;
            r_mem_data_out <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        r_state      <= S_ACCESS;
                        r_dmem_req   <= 1'b1;
                        r_dmem_addr  <= addr_in;
                        r_dmem_we    <= mem_write_in;
                        r_dmem_wdata <= w_store_data;
                        r_cnt        <= 8'd0;
                    end
                end
                S_ACCESS: begin
                    if (dmem.dmem_valid | w_timeout) begin
                        r_state    <= S_IDLE;
                        r_dmem_req <= 1'b0;
                        // A real response wins over a coincident timeout.
                        if (!r_dmem_we) begin
                            r_mem_data_out <= dmem.dmem_valid ? dmem.dmem_rdata : 16'h0000;
                        end
                        if (!dmem.dmem_valid) begin
                            r_mem_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_dmem_req <= 1'b0;
                end
            endcase
        end
    end

    // MEM/WB register: a stall inserts a bubble by clearing only the WB
    // controls, so no RegWrite or Halt leaks past an outstanding access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_out       <= 4'd0;
            r_dst_reg_out  <= 4'd0;
            r_alu_data_out <= 16'h0000;
        end else if (w_stall) begin
            r_wb_out <= 4'd0;
        end else begin
            r_wb_out       <= wb_in;
            r_dst_reg_out  <= dst_reg_in;
            r_alu_data_out <= addr_in;
        end
    end

    assign dmem.dmem_req   = r_dmem_req;
    assign dmem.dmem_we    = r_dmem_we;
    assign dmem.dmem_addr  = r_dmem_addr;
    assign dmem.dmem_wdata = r_dmem_wdata;
    assign mem_err         = r_mem_err;
    assign wb_out          = r_wb_out;
    assign dst_reg_out     = r_dst_reg_out;
    assign alu_data_out    = r_alu_data_out;
    assign mem_data_out    = r_mem_data_out;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
`timescale 1ns/1ps

module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [15:0] addr_in;
    logic [15:0] wdata_in;
    logic [3:0]  src_reg2_in;
    logic [3:0]  dst_reg_in;
    logic [3:0]  wb_in;
    logic        mem_stall;
    logic        mem_err;
    logic [3:0]  wb_out;
    logic [3:0]  dst_reg_out;
    logic [15:0] alu_data_out;
    logic [15:0] mem_data_out;

    int n_vec  = 0;
    int n_miss = 0;

`ifdef MEM2MEM_FWD_EN
    localparam logic [15:0] FWD_DATA = 16'hA5A5;
`else
    localparam logic [15:0] FWD_DATA = 16'h0000;
`endif

    mem_stage_ctrl_if dmem_bus ();

    mem_stage_ctrl #(.MAX_WAIT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read_in  (mem_read_in),
        .mem_write_in (mem_write_in),
        .addr_in      (addr_in),
        .wdata_in     (wdata_in),
        .src_reg2_in  (src_reg2_in),
        .dst_reg_in   (dst_reg_in),
        .wb_in        (wb_in),
        .dmem         (dmem_bus.master),
        .mem_stall    (mem_stall),
        .mem_err      (mem_err),
        .wb_out       (wb_out),
        .dst_reg_out  (dst_reg_out),
        .alu_data_out (alu_data_out),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [3:0]  src;
        logic [3:0]  dst;
        logic [3:0]  wb;
        logic        valid;
        logic [15:0] rdata;
        logic        e_stall;
        logic        e_req;
        logic        e_we;
        logic [15:0] e_daddr;
        logic [15:0] e_dwdata;
        logic [3:0]  e_wb;
        logic [3:0]  e_dst;
        logic [15:0] e_alu;
        logic [15:0] e_mdata;
        logic        e_err;
    } vec_t;

    vec_t vec[$];

    function automatic vec_t row(
        input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
        input logic [3:0] src, input logic [3:0] dst, input logic [3:0] wb,
        input logic valid, input logic [15:0] rdata,
        input logic e_stall, input logic e_req, input logic e_we,
        input logic [15:0] e_daddr, input logic [15:0] e_dwdata,
        input logic [3:0] e_wb, input logic [3:0] e_dst,
        input logic [15:0] e_alu, input logic [15:0] e_mdata, input logic e_err);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.src = src; v.dst = dst;
        v.wb = wb; v.valid = valid; v.rdata = rdata;
        v.e_stall = e_stall; v.e_req = e_req; v.e_we = e_we; v.e_daddr = e_daddr;
        v.e_dwdata = e_dwdata; v.e_wb = e_wb; v.e_dst = e_dst; v.e_alu = e_alu;
        v.e_mdata = e_mdata; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] wd,
                         input logic [3:0] s, input logic [3:0] d, input logic [3:0] w,
                         input logic v, input logic [15:0] rdat);
        mem_read_in          = rd;
        mem_write_in         = wr;
        addr_in              = a;
        wdata_in             = wd;
        src_reg2_in          = s;
        dst_reg_in           = d;
        wb_in                = w;
        dmem_bus.dmem_valid  = v;
        dmem_bus.dmem_rdata  = rdat;
    endtask

    task automatic chk_all(input string tag, input logic e_stall, input logic e_req, input logic e_we,
                           input logic [15:0] e_daddr, input logic [15:0] e_dwdata,
                           input logic [3:0] e_wb, input logic [3:0] e_dst,
                           input logic [15:0] e_alu, input logic [15:0] e_mdata, input logic e_err);
        n_vec++;
        chk({tag, " stall"}, 16'(mem_stall),             16'(e_stall));
        chk({tag, " req"},   16'(dmem_bus.dmem_req),     16'(e_req));
        chk({tag, " we"},    16'(dmem_bus.dmem_we),      16'(e_we));
        chk({tag, " daddr"}, dmem_bus.dmem_addr,         e_daddr);
        chk({tag, " dwdata"},dmem_bus.dmem_wdata,        e_dwdata);
        chk({tag, " wb"},    16'(wb_out),                16'(e_wb));
        chk({tag, " dst"},   16'(dst_reg_out),           16'(e_dst));
        chk({tag, " alu"},   alu_data_out,               e_alu);
        chk({tag, " mdata"}, mem_data_out,               e_mdata);
        chk({tag, " err"},   16'(mem_err),               16'(e_err));
        $display("%s: stall=%b req=%b we=%b addr=%h wdata=%h wb=%h dst=%h alu=%h mdata=%h err=%b",
                 tag, mem_stall, dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr,
                 dmem_bus.dmem_wdata, wb_out, dst_reg_out, alu_data_out, mem_data_out, mem_err);
    endtask

    initial begin
        // Cycle trace: load (valid on 4th ACCESS cycle), ALU passthrough,
        // store (valid on 2nd ACCESS cycle), valid-in-IDLE, minimum-latency
        // load followed by a store of its result, r0 no-forward case.
        vec.push_back(row(1,0,16'h0040,16'h0000,4'd0,4'd5,4'hC,0,16'h0000, 1,0,0,16'h0000,16'h0000,4'h0,4'd0,16'h0000,16'h0000,0));
        vec.push_back(row(1,0,16'h0040,16'h0000,4'd0,4'd5,4'hC,0,16'h0000, 1,1,0,16'h0040,16'h0000,4'h0,4'd0,16'h0000,16'h0000,0));
        vec.push_back(row(1,0,16'h0040,16'h0000,4'd0,4'd5,4'hC,0,16'h0000, 1,1,0,16'h0040,16'h0000,4'h0,4'd0,16'h0000,16'h0000,0));
        vec.push_back(row(1,0,16'h0040,16'h0000,4'd0,4'd5,4'hC,0,16'h0000, 1,1,0,16'h0040,16'h0000,4'h0,4'd0,16'h0000,16'h0000,0));
        vec.push_back(row(1,0,16'h0040,16'h0000,4'd0,4'd5,4'hC,1,16'hBEEF, 0,1,0,16'h0040,16'h0000,4'h0,4'd0,16'h0000,16'h0000,0));
        vec.push_back(row(0,0,16'h00FF,16'h0000,4'd0,4'd2,4'h8,0,16'h0000, 0,0,0,16'h0040,16'h0000,4'hC,4'd5,16'h0040,16'hBEEF,0));
        vec.push_back(row(0,1,16'h0010,16'h1234,4'd7,4'd0,4'h0,0,16'h0000, 1,0,0,16'h0040,16'h0000,4'h8,4'd2,16'h00FF,16'hBEEF,0));
        vec.push_back(row(0,1,16'h0010,16'h1234,4'd7,4'd0,4'h0,0,16'h0000, 1,1,1,16'h0010,16'h1234,4'h0,4'd2,16'h00FF,16'hBEEF,0));
        vec.push_back(row(0,1,16'h0010,16'h1234,4'd7,4'd0,4'h0,1,16'hDEAD, 0,1,1,16'h0010,16'h1234,4'h0,4'd2,16'h00FF,16'hBEEF,0));
        vec.push_back(row(0,0,16'h0000,16'h0000,4'd0,4'd0,4'h0,1,16'h1111, 0,0,1,16'h0010,16'h1234,4'h0,4'd0,16'h0010,16'hBEEF,0));
        vec.push_back(row(1,0,16'h0080,16'h0000,4'd0,4'd3,4'hC,0,16'h0000, 1,0,1,16'h0010,16'h1234,4'h0,4'd0,16'h0000,16'hBEEF,0));
        vec.push_back(row(1,0,16'h0080,16'h0000,4'd0,4'd3,4'hC,1,16'hA5A5, 0,1,0,16'h0080,16'h0000,4'h0,4'd0,16'h0000,16'hBEEF,0));
        vec.push_back(row(0,1,16'h0020,16'h0000,4'd3,4'd0,4'h0,0,16'h0000, 1,0,0,16'h0080,16'h0000,4'hC,4'd3,16'h0080,16'hA5A5,0));
        vec.push_back(row(0,1,16'h0020,16'h0000,4'd3,4'd0,4'h0,0,16'h0000, 1,1,1,16'h0020,FWD_DATA,4'h0,4'd3,16'h0080,16'hA5A5,0));
        vec.push_back(row(0,1,16'h0020,16'h0000,4'd3,4'd0,4'h0,1,16'h0000, 0,1,1,16'h0020,FWD_DATA,4'h0,4'd3,16'h0080,16'hA5A5,0));
        vec.push_back(row(0,0,16'h7777,16'h0000,4'd0,4'd0,4'h8,0,16'h0000, 0,0,1,16'h0020,FWD_DATA,4'h0,4'd0,16'h0020,16'hA5A5,0));
        vec.push_back(row(0,1,16'h0030,16'h5555,4'd0,4'd0,4'h0,0,16'h0000, 1,0,1,16'h0020,FWD_DATA,4'h8,4'd0,16'h7777,16'hA5A5,0));
        vec.push_back(row(0,1,16'h0030,16'h5555,4'd0,4'd0,4'h0,1,16'h0000, 0,1,1,16'h0030,16'h5555,4'h0,4'd0,16'h7777,16'hA5A5,0));
        vec.push_back(row(0,0,16'h0000,16'h0000,4'd0,4'd0,4'h0,0,16'h0000, 0,0,1,16'h0030,16'h5555,4'h0,4'd0,16'h0030,16'hA5A5,0));

        // Reset state, with a load presented so the stall gating is visible.
        drive(1, 0, 16'h0040, 16'h0000, 4'd0, 4'd5, 4'hC, 0, 16'h0000);
        repeat (2) @(negedge clk);
        chk_all("reset", 0,0,0,16'h0000,16'h0000,4'h0,4'd0,16'h0000,16'h0000,0);
        drive(0, 0, 16'h0000, 16'h0000, 4'd0, 4'd0, 4'h0, 0, 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < vec.size(); i++) begin
            @(posedge clk); #1;
            drive(vec[i].rd, vec[i].wr, vec[i].addr, vec[i].wdata, vec[i].src,
                  vec[i].dst, vec[i].wb, vec[i].valid, vec[i].rdata);
            @(negedge clk);
            chk_all($sformatf("row%0d", i), vec[i].e_stall, vec[i].e_req, vec[i].e_we,
                    vec[i].e_daddr, vec[i].e_dwdata, vec[i].e_wb, vec[i].e_dst,
                    vec[i].e_alu, vec[i].e_mdata, vec[i].e_err);
        end

        // Timeout: load (with Halt behind it in wb) that never gets valid.
        @(posedge clk); #1;
        drive(1, 0, 16'h0100, 16'h0000, 4'd0, 4'd4, 4'hD, 0, 16'h0000);
        @(negedge clk);
        chk_all("to idle", 1,0,1,16'h0030,16'h5555,4'h0,4'd0,16'h0000,16'hA5A5,0);
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk_all($sformatf("to acc%0d", k), (k != 15), 1, 0, 16'h0100, 16'h0000,
                    4'h0, 4'd0, 16'h0000, 16'hA5A5, 0);
        end
        @(posedge clk); #1;
        drive(0, 0, 16'h0000, 16'h0000, 4'd0, 4'd0, 4'h0, 0, 16'h0000);
        @(negedge clk);
        chk_all("to done", 0,0,0,16'h0100,16'h0000,4'hD,4'd4,16'h0100,16'h0000,1);

        // mem_err remains set across a later successful store.
        @(posedge clk); #1;
        drive(0, 1, 16'h0050, 16'h9999, 4'd0, 4'd0, 4'h0, 0, 16'h0000);
        @(negedge clk);
        chk_all("st idle", 1,0,0,16'h0100,16'h0000,4'h0,4'd0,16'h0000,16'h0000,1);
        @(posedge clk); #1;
        dmem_bus.dmem_valid = 1'b1;
        @(negedge clk);
        chk_all("st acc", 0,1,1,16'h0050,16'h9999,4'h0,4'd0,16'h0000,16'h0000,1);
        @(posedge clk); #1;
        drive(0, 0, 16'h0000, 16'h0000, 4'd0, 4'd0, 4'h0, 0, 16'h0000);
        @(negedge clk);
        chk_all("st done", 0,0,1,16'h0050,16'h9999,4'h0,4'd0,16'h0050,16'h0000,1);

        // Reset in the third ACCESS cycle of a load.
        @(posedge clk); #1;
        drive(1, 0, 16'h0200, 16'h0000, 4'd0, 4'd6, 4'hC, 0, 16'h0000);
        @(negedge clk);
        chk_all("rs idle", 1,0,1,16'h0050,16'h9999,4'h0,4'd0,16'h0000,16'h0000,1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk_all($sformatf("rs acc%0d", k), 1,1,0,16'h0200,16'h0000,4'h0,4'd0,16'h0000,16'h0000,1);
        end
        #1 rst = 1'b1;
        #1;
        chk_all("rs async", 0,0,0,16'h0000,16'h0000,4'h0,4'd0,16'h0000,16'h0000,0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all("rs restart", 1,0,0,16'h0000,16'h0000,4'h0,4'd0,16'h0000,16'h0000,0);
        @(posedge clk); #1;
        dmem_bus.dmem_valid = 1'b1;
        dmem_bus.dmem_rdata = 16'h4242;
        @(negedge clk);
        chk_all("rs acc", 0,1,0,16'h0200,16'h0000,4'h0,4'd0,16'h0000,16'h0000,0);
        @(posedge clk); #1;
        drive(0, 0, 16'h0000, 16'h0000, 4'd0, 4'd0, 4'h0, 0, 16'h0000);
        @(negedge clk);
        chk_all("rs done", 0,0,0,16'h0200,16'h0000,4'hC,4'd6,16'h0200,16'h4242,0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
